aludec_stage: RTL and testbench
===============================

# aludec_stage

Registered, parametrised successor to the combinational ALU decoder. It sits between the main decoder and the execute stage. It decodes the full RV32I ALU and branch set (adding SRA, SLTU and unsigned branch compares) plus optional RV32M, and registers the result into a one-entry pipeline slot with a valid/ready handshake and flush. DIV/DIVU/REM/REMU are held in the slot for a programmable number of cycles before being presented downstream.

## Interface
- `ALUCTRL_W`, default 5: width of `o_aluctrl`; must be ≥5.
- `EN_MEXT`, default 1: 1 decodes RV32M; 0 flags M encodings illegal.
- `DIV_LAT`, default 32: extra cycles a divide/remainder op waits in the slot; range 1..255.
- `i_clk` in, 1: clock; single clock domain.
- `i_rst_n` in, 1: asynchronous, active-low reset.
- `i_valid` in, 1: upstream instruction fields valid.
- `o_ready` out, 1: slot can accept this cycle.
- `i_opb5` in, 1: opcode bit 5 (1 = R-type/OP).
- `i_funct3` in, 3: funct3.
- `i_funct7b5` in, 1: funct7 bit 5.
- `i_funct7b0` in, 1: funct7 bit 0 (M-extension select).
- `i_aluop` in, 2: 00 add, 01 branch, 1x OP/OP-IMM.
- `i_flush` in, 1: kill slot contents and any pending wait.
- `o_valid` out, 1: slot holds a presentable op.
- `i_ready` in, 1: downstream accepts.
- `o_aluctrl` out, `ALUCTRL_W`: ALU op (`alu_op_e`).
- `o_branch_type` out, 3: 0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU.
- `o_illegal` out, 1: registered op is an undefined encoding.
- `o_busy` out, 1: slot in WAIT (divide pending).

## Operation
- ALU encodings: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLL 6, SRL 7, SRA 8, SLTU 9, MUL 10, MULH 11, MULHSU 12, MULHU 13, DIV 14, DIVU 15, REM 16, REMU 17.
- aluop 00: ADD, no branch.
- aluop 01 (branch):
  - BEQ/BNE → SUB.
  - BLT/BGE → SLT.
  - BLTU/BGEU → SLTU.
  - funct3 010/011 → illegal.
- aluop 1x, M op when `i_opb5 & i_funct7b0`: funct3 indexes MUL..REMU in order. If `EN_MEXT=0`, the op is illegal.
- aluop 1x, base ops:
  - funct3 000: SUB when `i_opb5 & i_funct7b5`, else ADD.
  - funct3 001: SLL; `i_funct7b5=1` is illegal.
  - funct3 010: SLT.
  - funct3 011: SLTU.
  - funct3 100: XOR.
  - funct3 101: SRA when `i_funct7b5`, else SRL.
  - funct3 110: OR.
  - funct3 111: AND.
- Illegal ops are registered with `o_aluctrl=ADD`, branch type 0 and `o_illegal=1`. They flow through the handshake like any other op.
- States:
  - EMPTY: `o_valid=0`, `o_ready=1`. Accept (`i_valid & o_ready`) goes to WAIT if the op is DIV..REMU, else to FULL.
  - FULL: `o_valid=1`, `o_ready=i_ready`. If `i_ready`: on a simultaneous accept, load the new op and go FULL or WAIT; otherwise go EMPTY. If not `i_ready`, hold all outputs stable.
  - WAIT: `o_valid=0`, `o_ready=0`, `o_busy=1`. The counter is loaded with `DIV_LAT-1` on entry and decrements each cycle. At count 0 the slot goes to FULL.
- Flush has priority over everything. The next state is EMPTY, the counter is cleared, and any same-cycle input is dropped. The registered fields are left unchanged (don't-care while `o_valid=0`).
- Reset values:
  - State EMPTY.
  - `o_valid=0`, `o_busy=0`, `o_illegal=0`.
  - `o_aluctrl=0`, `o_branch_type=0`, counter 0.
  - `o_ready=0` while `i_rst_n` is low.

## Timing
- Non-divide op accepted at edge N: outputs valid after edge N, so latency is 1.
- Divide op accepted at edge N: `o_busy` is high after N and `o_valid` rises after edge N+`DIV_LAT`.
- Back-to-back throughput is 1 op/cycle when `i_ready` is held high, because `o_ready` is combinational on `i_ready` in FULL.
- A reset assertion mid-WAIT returns immediately (asynchronously) to EMPTY.

## Structure
- `alu_pkg` holds:
  - `alu_op_e` (5-bit) and `br_type_e`.
  - Width constants.
  - The `is_multicycle()` function.
- Sub-module `alu_dec_comb`: the pure combinational decoder, producing op, branch type and illegal. `aludec_stage` instantiates it and owns the FSM, counter and output registers.

## Test plan
- Reset, then accept aluop=10, opb5=1, f3=101, f7b5=1 → after 1 edge `o_valid=1`, `o_aluctrl=8` (SRA).
- Branch f3=110 with `i_ready=1` → `o_aluctrl=9`, `o_branch_type=5`. Then f3=011 → `o_illegal=1`, `o_aluctrl=0`.
- `DIV_LAT=4`, accept DIVU (opb5=1, f7b0=1, f3=101) → `o_busy` high for 4 cycles, `o_ready=0`, then `o_valid=1` with `o_aluctrl=15`.
- `i_ready=0` with FULL holding XOR, then drive new input → outputs stable, `o_ready=0`. Raise `i_ready` → next op loads on the same edge as the handoff.
- `i_flush` during WAIT cycle 2 together with `i_valid` → next cycle EMPTY, `o_busy=0`, input dropped.
- `EN_MEXT=0`, MUL encoding → `o_illegal=1`. Async reset asserted mid-FULL → `o_valid` drops before the next clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU op / branch type encodings and helpers for the ALU decode stage
package alu_pkg;

  localparam int ALU_OP_W = 5;
  localparam int BR_W     = 3;
  localparam int CNT_W    = 8;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_AND    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_SLT    = 5'd5,
    ALU_SLL    = 5'd6,
    ALU_SRL    = 5'd7,
    ALU_SRA    = 5'd8,
    ALU_SLTU   = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17
  } alu_op_e;

  typedef enum logic [BR_W-1:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_LT   = 3'd3,
    BR_GE   = 3'd4,
    BR_LTU  = 3'd5,
    BR_GEU  = 3'd6
  } br_type_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_WAIT  = 2'd2
  } slot_state_e;

  function automatic logic is_multicycle(alu_op_e op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_dec_comb.sv
// rtl/alu_dec_comb.sv - combinational RV32I/RV32M ALU and branch decoder
module alu_dec_comb
  import alu_pkg::*;
#(
  parameter int EN_MEXT = 1
) (
  input  logic       opb5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       funct7b0,
  input  logic [1:0] aluop,
  output alu_op_e    op,
  output br_type_e   br_type,
  output logic       illegal
);

  always_comb begin
    op      = ALU_ADD;
    br_type = BR_NONE;
    illegal = 1'b0;
    if (aluop == 2'b01) begin
      case (funct3)
        3'b000:  begin op = ALU_SUB;  br_type = BR_EQ;  end
        3'b001:  begin op = ALU_SUB;  br_type = BR_NE;  end
        3'b100:  begin op = ALU_SLT;  br_type = BR_LT;  end
        3'b101:  begin op = ALU_SLT;  br_type = BR_GE;  end
        3'b110:  begin op = ALU_SLTU; br_type = BR_LTU; end
        3'b111:  begin op = ALU_SLTU; br_type = BR_GEU; end
        default: illegal = 1'b1;
      endcase
    end else if (aluop[1]) begin
      if (opb5 && funct7b0) begin
        if (EN_MEXT != 0) begin
          case (funct3)
            3'b000:  op = ALU_MUL;
            3'b001:  op = ALU_MULH;
            3'b010:  op = ALU_MULHSU;
            3'b011:  op = ALU_MULHU;
            3'b100:  op = ALU_DIV;
            3'b101:  op = ALU_DIVU;
            3'b110:  op = ALU_REM;
            default: op = ALU_REMU;
          endcase
        end else begin
          illegal = 1'b1;
        end
      end else begin
        case (funct3)
          3'b000:  op = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  begin
            if (funct7b5) illegal = 1'b1;
            else          op = ALU_SLL;
          end
          3'b010:  op = ALU_SLT;
          3'b011:  op = ALU_SLTU;
          3'b100:  op = ALU_XOR;
          3'b101:  op = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  op = ALU_OR;
          default: op = ALU_AND;
        endcase
      end
    end
  end

endmodule

// File: rtl/aludec_stage.sv
// rtl/aludec_stage.sv - registered ALU decode slot with valid/ready, flush and divide hold
module aludec_stage
  import alu_pkg::*;
#(
  parameter int ALUCTRL_W = 5,
  parameter int EN_MEXT   = 1,
  parameter int DIV_LAT   = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_opb5,
  input  logic [2:0]           i_funct3,
  input  logic                 i_funct7b5,
  input  logic                 i_funct7b0,
  input  logic [1:0]           i_aluop,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [ALUCTRL_W-1:0] o_aluctrl,
  output logic [2:0]           o_branch_type,
  output logic                 o_illegal,
  output logic                 o_busy
);

  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  alu_op_e     dec_op;
  br_type_e    dec_br;
  logic        dec_ill;

  slot_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  alu_op_e     op_q;
  br_type_e    br_q;
  logic        ill_q;
  logic        accept;
  logic        load;

  alu_dec_comb #(.EN_MEXT(EN_MEXT)) u_dec (
    .opb5     (i_opb5),
    .funct3   (i_funct3),
    .funct7b5 (i_funct7b5),
    .funct7b0 (i_funct7b0),
    .aluop    (i_aluop),
    .op       (dec_op),
    .br_type  (dec_br),
    .illegal  (dec_ill)
  );

  // Ready is held low during reset so nothing is accepted before the slot is initialised.
  assign o_ready = i_rst_n && ((state_q == ST_EMPTY) || ((state_q == ST_FULL) && i_ready));
  assign accept  = i_valid && o_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          load    = 1'b1;
          state_d = is_multicycle(dec_op) ? ST_WAIT : ST_FULL;
          cnt_d   = is_multicycle(dec_op) ? DIV_LOAD : '0;
        end
      end
      ST_FULL: begin
        if (i_ready) begin
          if (accept) begin
            load    = 1'b1;
            state_d = is_multicycle(dec_op) ? ST_WAIT : ST_FULL;
            cnt_d   = is_multicycle(dec_op) ? DIV_LOAD : '0;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_FULL;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_EMPTY;
    endcase
    if (i_flush) begin
      state_d = ST_EMPTY;
      cnt_d   = '0;
      load    = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_EMPTY;
      cnt_q   <= '0;
      op_q    <= ALU_ADD;
      br_q    <= BR_NONE;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        op_q  <= dec_op;
        br_q  <= dec_br;
        ill_q <= dec_ill;
      end
    end
  end

  assign o_valid       = (state_q == ST_FULL);
  assign o_busy        = (state_q == ST_WAIT);
  assign o_aluctrl     = ALUCTRL_W'(op_q);
  assign o_branch_type = br_q;
  assign o_illegal     = ill_q;

endmodule

// File: tb/tb_aludec_stage.sv
// tb/tb_aludec_stage.sv - directed bench for aludec_stage
module tb_aludec_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid, flush, rdy;
  logic       opb5, f7b5, f7b0;
  logic [2:0] f3;
  logic [1:0] aluop;

  logic       o_ready, o_valid, o_illegal, o_busy;
  logic [4:0] o_aluctrl;
  logic [2:0] o_br;

  logic       nm_ready, nm_valid, nm_illegal, nm_busy;
  logic [4:0] nm_aluctrl;
  logic [2:0] nm_br;

  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  aludec_stage #(.ALUCTRL_W(5), .EN_MEXT(1), .DIV_LAT(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(o_ready),
    .i_opb5(opb5), .i_funct3(f3), .i_funct7b5(f7b5), .i_funct7b0(f7b0),
    .i_aluop(aluop), .i_flush(flush), .o_valid(o_valid), .i_ready(rdy),
    .o_aluctrl(o_aluctrl), .o_branch_type(o_br), .o_illegal(o_illegal), .o_busy(o_busy)
  );

  aludec_stage #(.ALUCTRL_W(5), .EN_MEXT(0), .DIV_LAT(4)) dut_nm (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(nm_ready),
    .i_opb5(opb5), .i_funct3(f3), .i_funct7b5(f7b5), .i_funct7b0(f7b0),
    .i_aluop(aluop), .i_flush(flush), .o_valid(nm_valid), .i_ready(rdy),
    .o_aluctrl(nm_aluctrl), .o_branch_type(nm_br), .o_illegal(nm_illegal), .o_busy(nm_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] ao, input logic b5,
                       input logic [2:0] fn3, input logic s7b5, input logic s7b0);
    valid = v; aluop = ao; opb5 = b5; f3 = fn3; f7b5 = s7b5; f7b0 = s7b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; rdy = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0);
    #1;
    check("rst_ready", o_ready, 0);
    check("rst_valid", o_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_illegal", o_illegal, 0);
    check("rst_aluctrl", o_aluctrl, 0);
    check("rst_br", o_br, 0);
    step(); step();
    rst_n = 1'b1;
    #1;
    check("empty_ready", o_ready, 1);

    // SRA
    rdy = 1'b1;
    drive(1'b1, 2'b10, 1'b1, 3'b101, 1'b1, 1'b0);
    step();
    check("sra_valid", o_valid, 1);
    check("sra_aluctrl", o_aluctrl, 8);
    check("sra_illegal", o_illegal, 0);

    // BLTU back-to-back
    drive(1'b1, 2'b01, 1'b0, 3'b110, 1'b0, 1'b0);
    check("b2b_ready", o_ready, 1);
    step();
    check("bltu_aluctrl", o_aluctrl, 9);
    check("bltu_br", o_br, 5);
    check("bltu_valid", o_valid, 1);

    // illegal branch funct3
    drive(1'b1, 2'b01, 1'b0, 3'b011, 1'b0, 1'b0);
    step();
    check("brill_illegal", o_illegal, 1);
    check("brill_aluctrl", o_aluctrl, 0);
    check("brill_br", o_br, 0);
    check("brill_valid", o_valid, 1);

    drive(1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0);
    step();
    check("drain_valid", o_valid, 0);

    // DIVU with DIV_LAT=4
    drive(1'b1, 2'b10, 1'b1, 3'b101, 1'b0, 1'b1);
    step();
    drive(1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0);
    check("div_busy0", o_busy, 1);
    check("div_ready0", o_ready, 0);
    check("div_valid0", o_valid, 0);
    for (int i = 1; i < 4; i++) begin
      step();
      check($sformatf("div_busy%0d", i), o_busy, 1);
      check($sformatf("div_valid%0d", i), o_valid, 0);
    end
    step();
    check("divu_valid", o_valid, 1);
    check("divu_aluctrl", o_aluctrl, 15);
    check("divu_busy", o_busy, 0);

    // XOR then stall
    drive(1'b1, 2'b10, 1'b1, 3'b100, 1'b0, 1'b0);
    step();
    check("xor_aluctrl", o_aluctrl, 4);
    rdy = 1'b0;
    drive(1'b1, 2'b10, 1'b1, 3'b110, 1'b0, 1'b0);
    #1;
    check("stall_ready", o_ready, 0);
    step();
    check("stall_aluctrl1", o_aluctrl, 4);
    check("stall_valid1", o_valid, 1);
    step();
    check("stall_aluctrl2", o_aluctrl, 4);
    rdy = 1'b1;
    #1;
    check("unstall_ready", o_ready, 1);
    step();
    check("or_aluctrl", o_aluctrl, 3);
    check("or_valid", o_valid, 1);
    drive(1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0);
    step();
    check("drain2_valid", o_valid, 0);

    // flush during WAIT cycle 2
    drive(1'b1, 2'b10, 1'b1, 3'b100, 1'b0, 1'b1);
    step();
    drive(1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0);
    step();
    check("flushpre_busy", o_busy, 1);
    flush = 1'b1;
    drive(1'b1, 2'b10, 1'b0, 3'b100, 1'b0, 1'b0);
    step();
    flush = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0);
    check("flush_busy", o_busy, 0);
    check("flush_valid", o_valid, 0);
    check("flush_ready", o_ready, 1);
    step();
    check("flush_dropped", o_valid, 0);
    for (int i = 0; i < 4; i++) step();
    check("flush_nowake", o_valid, 0);

    // MUL: legal with M, illegal without
    drive(1'b1, 2'b10, 1'b1, 3'b000, 1'b0, 1'b1);
    step();
    drive(1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0);
    rdy = 1'b0;
    check("mul_aluctrl", o_aluctrl, 10);
    check("mul_illegal", o_illegal, 0);
    check("nm_mul_valid", nm_valid, 1);
    check("nm_mul_illegal", nm_illegal, 1);
    check("nm_mul_aluctrl", nm_aluctrl, 0);

    // async reset mid-FULL
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_valid", o_valid, 0);
    check("areset_ready", o_ready, 0);
    check("areset_aluctrl", o_aluctrl, 0);
    step();
    rst_n = 1'b1;
    rdy = 1'b1;

    // async reset mid-WAIT
    drive(1'b1, 2'b10, 1'b1, 3'b110, 1'b0, 1'b1);
    step();
    drive(1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0);
    check("rem_busy", o_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_wait_busy", o_busy, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("areset_wait_idle", o_valid, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
